// File: rtl/commit_stage_pkg.sv
// Shared types for the commit stage: the WB->commit record, trap code and retirement FSM states.
// Every commit_stage file imports this package.
package commit_stage_pkg;

  localparam int COMMIT_DEPTH = 4;
  localparam int COMMIT_CNT_W = 64;

  typedef logic [3:0] trap_t;

  typedef struct packed {
    logic        valid;
    logic [63:0] pc;
    logic [31:0] instr;
    logic [63:0] inst_counter;
    logic        difftest_skip;
    trap_t       trap;
  } wb_commit;

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    DRAIN  = 2'd1,
    HALTED = 2'd2
  } commit_state_t;

  function automatic logic is_trap(input wb_commit c);
    return c.trap != '0;
  endfunction

endpackage

// File: rtl/commit_fifo.sv
// Generic DEPTH-entry queue of wb_commit records.
// The head entry is read combinationally, so an entry pushed in one cycle is visible in the next.
module commit_fifo
  import commit_stage_pkg::*;
#(
  parameter int DEPTH = COMMIT_DEPTH
) (
  input  logic     clk,
  input  logic     reset,
  input  logic     push,
  input  wb_commit push_data,
  input  logic     pop,
  output wb_commit head,
  output logic     full,
  output logic     empty
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  wb_commit           mem [DEPTH];
  logic [PTR_W-1:0]   wr_ptr_reg;
  logic [PTR_W-1:0]   rd_ptr_reg;
  logic [CNT_W-1:0]   count_reg;
  logic               push_ok;
  logic               pop_ok;

  assign full    = (count_reg == CNT_W'(DEPTH));
  assign empty   = (count_reg == '0);
  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;
  assign head    = mem[rd_ptr_reg];

  // Storage carries no reset; the pointers and count define what is live.
  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr_reg] <= push_data;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (push_ok) wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
      if (pop_ok)  rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
      case ({push_ok, pop_ok})
        2'b10:   count_reg <= count_reg + CNT_W'(1);
        2'b01:   count_reg <= count_reg - CNT_W'(1);
        default: count_reg <= count_reg;
      endcase
    end
  end

endmodule

// File: rtl/commit_stage.sv
// Retirement sink for WB: queues commits, presents one per cycle to difftest, checks ordering,
// counts cycles/instret and halts after a trap entry retires.
module commit_stage
  import commit_stage_pkg::*;
#(
  parameter int DEPTH = COMMIT_DEPTH,
  parameter int CNT_W = COMMIT_CNT_W
) (
  input  logic             clk,
  input  logic             reset,
  input  wb_commit         in_commit,
  output logic             in_ready,
  output logic             out_valid,
  input  logic             out_ready,
  output wb_commit         out_commit,
  output logic             halt,
  output trap_t            halt_trap,
  output logic             order_err,
  output logic [CNT_W-1:0] cycle_cnt,
  output logic [CNT_W-1:0] instret_cnt
);

  commit_state_t    state_reg;
  commit_state_t    state_next;
  wb_commit         head;
  logic             fifo_full;
  logic             fifo_empty;
  logic             push;
  logic             pop;
  logic [63:0]      expected_reg;
  logic             order_err_reg;
  logic             halt_reg;
  trap_t            halt_trap_reg;
  logic [CNT_W-1:0] cycle_cnt_reg;
  logic [CNT_W-1:0] instret_cnt_reg;

  assign in_ready  = !fifo_full && (state_reg == RUN);
  assign out_valid = !fifo_empty && (state_reg != HALTED);
  assign push      = in_commit.valid && in_ready;
  assign pop       = out_valid && out_ready;

  commit_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (push),
    .push_data (in_commit),
    .pop       (pop),
    .head      (head),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  always_comb begin
    out_commit       = head;
    out_commit.valid = out_valid;
  end

  // A queued trap blocks further pushes, so only one trap can ever be in flight.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      RUN:     if (push && is_trap(in_commit)) state_next = DRAIN;
      DRAIN:   if (pop && is_trap(head))       state_next = HALTED;
      HALTED:  state_next = HALTED;
      default: state_next = RUN;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg       <= RUN;
      expected_reg    <= '0;
      order_err_reg   <= 1'b0;
      halt_reg        <= 1'b0;
      halt_trap_reg   <= '0;
      cycle_cnt_reg   <= '0;
      instret_cnt_reg <= '0;
    end else begin
      state_reg     <= state_next;
      cycle_cnt_reg <= cycle_cnt_reg + CNT_W'(1);
      if (pop) begin
        if (head.inst_counter != expected_reg) order_err_reg <= 1'b1;
        expected_reg <= head.inst_counter + 64'd1;
        if (!head.difftest_skip) instret_cnt_reg <= instret_cnt_reg + CNT_W'(1);
        if (state_reg == DRAIN && is_trap(head)) begin
          halt_reg      <= 1'b1;
          halt_trap_reg <= head.trap;
        end
      end
    end
  end

  assign halt        = halt_reg;
  assign halt_trap   = halt_trap_reg;
  assign order_err   = order_err_reg;
  assign cycle_cnt   = cycle_cnt_reg;
  assign instret_cnt = instret_cnt_reg;

endmodule

// File: tb/tb_commit_stage.sv
// Directed bench for commit_stage: streaming, backpressure, full push+pop, ordering, trap halt,
// difftest_skip accounting and asynchronous reset mid-stream.
module tb_commit_stage;
  import commit_stage_pkg::*;

  logic        clk;
  logic        reset;
  wb_commit    in_commit;
  logic        in_ready;
  logic        out_valid;
  logic        out_ready;
  wb_commit    out_commit;
  logic        halt;
  trap_t       halt_trap;
  logic        order_err;
  logic [63:0] cycle_cnt;
  logic [63:0] instret_cnt;

  int n_checks = 0;
  int n_fail   = 0;

  commit_stage dut (
    .clk         (clk),
    .reset       (reset),
    .in_commit   (in_commit),
    .in_ready    (in_ready),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_commit  (out_commit),
    .halt        (halt),
    .halt_trap   (halt_trap),
    .order_err   (order_err),
    .cycle_cnt   (cycle_cnt),
    .instret_cnt (instret_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One line per retired commit.
  always @(posedge clk) begin
    if (reset && out_valid && out_ready)
      $display("commit: inst_counter=%0d skip=%0b trap=%0h", out_commit.inst_counter,
               out_commit.difftest_skip, out_commit.trap);
  end

  function automatic wb_commit mk(input int cnt, input logic skip, input trap_t trap);
    wb_commit c;
    c.valid         = 1'b1;
    c.pc            = 64'h8000_0000 + 64'(cnt) * 4;
    c.instr         = 32'h0000_0013 + 32'(cnt);
    c.inst_counter  = 64'(cnt);
    c.difftest_skip = skip;
    c.trap          = trap;
    return c;
  endfunction

  task automatic do_reset();
    reset     = 1'b0;
    in_commit = '0;
    out_ready = 1'b0;
    @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic test_reset();
    reset     = 1'b1;
    in_commit = '0;
    out_ready = 1'b0;
    @(negedge clk);
    #2 reset = 1'b0;
    #1;
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid got=%0b want=0", out_valid); end
    n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready got=%0b want=1", in_ready); end
    n_checks++; if ({halt, order_err} !== 2'b00) begin n_fail++; $display("FAIL reset_flags got=%b want=00", {halt, order_err}); end
    n_checks++; if (halt_trap !== 4'h0) begin n_fail++; $display("FAIL reset_halt_trap got=%0h want=0", halt_trap); end
    n_checks++; if (cycle_cnt !== 64'd0 || instret_cnt !== 64'd0) begin n_fail++; $display("FAIL reset_counters got=%0d/%0d want=0/0", cycle_cnt, instret_cnt); end
    @(negedge clk);
    reset = 1'b1;
    repeat (3) @(negedge clk);
    n_checks++; if (cycle_cnt !== 64'd3) begin n_fail++; $display("FAIL cycle_cnt got=%0d want=3", cycle_cnt); end
  endtask

  task automatic test_back_to_back();
    do_reset();
    out_ready = 1'b1;
    in_commit = mk(0, 1'b0, 4'h0);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      n_checks++; if (out_valid !== 1'b1 || out_commit.inst_counter !== 64'(i)) begin n_fail++; $display("FAIL stream_head[%0d] got valid=%0b cnt=%0d want valid=1 cnt=%0d", i, out_valid, out_commit.inst_counter, i); end
      n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL stream_in_ready[%0d] got=%0b want=1", i, in_ready); end
      if (i < 9) in_commit = mk(i + 1, 1'b0, 4'h0);
      else       in_commit = '0;
    end
    @(negedge clk);
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL stream_drained got=%0b want=0", out_valid); end
    n_checks++; if (instret_cnt !== 64'd10) begin n_fail++; $display("FAIL stream_instret got=%0d want=10", instret_cnt); end
    n_checks++; if (order_err !== 1'b0) begin n_fail++; $display("FAIL stream_order_err got=%0b want=0", order_err); end
  endtask

  task automatic test_backpressure();
    do_reset();
    for (int i = 0; i < 6; i++) begin
      in_commit = mk(i, 1'b0, 4'h0);
      n_checks++; if (in_ready !== (i < 4)) begin n_fail++; $display("FAIL bp_in_ready[%0d] got=%0b want=%0b", i, in_ready, (i < 4)); end
      @(negedge clk);
    end
    in_commit = '0;
    out_ready = 1'b1;
    for (int j = 0; j < 4; j++) begin
      n_checks++; if (out_valid !== 1'b1 || out_commit.inst_counter !== 64'(j)) begin n_fail++; $display("FAIL bp_release[%0d] got valid=%0b cnt=%0d want valid=1 cnt=%0d", j, out_valid, out_commit.inst_counter, j); end
      @(negedge clk);
    end
    n_checks++; if (out_valid !== 1'b0 || instret_cnt !== 64'd4) begin n_fail++; $display("FAIL bp_after got valid=%0b instret=%0d want valid=0 instret=4", out_valid, instret_cnt); end
  endtask

  task automatic test_full_push_pop();
    do_reset();
    for (int i = 0; i < 4; i++) begin
      in_commit = mk(i, 1'b0, 4'h0);
      @(negedge clk);
    end
    in_commit = mk(4, 1'b0, 4'h0);
    out_ready = 1'b1;
    n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL full_in_ready got=%0b want=0", in_ready); end
    @(negedge clk);
    in_commit = '0;
    out_ready = 1'b0;
    n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL full_in_ready_next got=%0b want=1", in_ready); end
    n_checks++; if (out_commit.inst_counter !== 64'd1) begin n_fail++; $display("FAIL full_head got=%0d want=1", out_commit.inst_counter); end
    out_ready = 1'b1;
    for (int j = 1; j < 4; j++) begin
      n_checks++; if (out_valid !== 1'b1 || out_commit.inst_counter !== 64'(j)) begin n_fail++; $display("FAIL full_drain[%0d] got valid=%0b cnt=%0d want valid=1 cnt=%0d", j, out_valid, out_commit.inst_counter, j); end
      @(negedge clk);
    end
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL full_no_push got=%0b want=0", out_valid); end
  endtask

  task automatic test_order();
    do_reset();
    out_ready = 1'b1;
    in_commit = mk(0, 1'b0, 4'h0);
    @(negedge clk);
    in_commit = mk(1, 1'b0, 4'h0);
    @(negedge clk);
    n_checks++; if (order_err !== 1'b0) begin n_fail++; $display("FAIL order_before got=%0b want=0", order_err); end
    in_commit = mk(3, 1'b0, 4'h0);
    @(negedge clk);
    n_checks++; if (order_err !== 1'b0 || out_commit.inst_counter !== 64'd3) begin n_fail++; $display("FAIL order_head3 got err=%0b cnt=%0d want err=0 cnt=3", order_err, out_commit.inst_counter); end
    in_commit = '0;
    @(negedge clk);
    n_checks++; if (order_err !== 1'b1) begin n_fail++; $display("FAIL order_err_set got=%0b want=1", order_err); end
    n_checks++; if (instret_cnt !== 64'd3) begin n_fail++; $display("FAIL order_instret got=%0d want=3", instret_cnt); end
    in_commit = mk(4, 1'b0, 4'h0);
    @(negedge clk);
    in_commit = '0;
    @(negedge clk);
    n_checks++; if (order_err !== 1'b1 || instret_cnt !== 64'd4) begin n_fail++; $display("FAIL order_sticky got err=%0b instret=%0d want err=1 instret=4", order_err, instret_cnt); end
  endtask

  task automatic test_trap();
    do_reset();
    in_commit = mk(3, 1'b0, 4'h0);
    @(negedge clk);
    in_commit = mk(4, 1'b0, 4'h0);
    @(negedge clk);
    in_commit = mk(5, 1'b0, 4'h9);
    @(negedge clk);
    n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL trap_in_ready got=%0b want=0", in_ready); end
    in_commit = mk(6, 1'b0, 4'h0);
    out_ready = 1'b1;
    for (int k = 3; k < 6; k++) begin
      n_checks++; if (out_valid !== 1'b1 || out_commit.inst_counter !== 64'(k) || halt !== 1'b0) begin n_fail++; $display("FAIL trap_drain[%0d] got valid=%0b cnt=%0d halt=%0b want valid=1 cnt=%0d halt=0", k, out_valid, out_commit.inst_counter, halt, k); end
      @(negedge clk);
    end
    n_checks++; if (halt !== 1'b1 || halt_trap !== 4'h9) begin n_fail++; $display("FAIL trap_halt got halt=%0b trap=%0h want halt=1 trap=9", halt, halt_trap); end
    n_checks++; if (out_valid !== 1'b0 || in_ready !== 1'b0) begin n_fail++; $display("FAIL trap_halted_io got valid=%0b ready=%0b want 0/0", out_valid, in_ready); end
    n_checks++; if (instret_cnt !== 64'd3) begin n_fail++; $display("FAIL trap_instret got=%0d want=3", instret_cnt); end
    in_commit = '0;
    @(negedge clk);
  endtask

  task automatic test_skip_and_reset();
    do_reset();
    out_ready = 1'b1;
    in_commit = mk(0, 1'b0, 4'h0);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (i < 4) in_commit = mk(i + 1, (i + 1 == 1) || (i + 1 == 3), 4'h0);
      else       in_commit = '0;
    end
    @(negedge clk);
    n_checks++; if (instret_cnt !== 64'd3) begin n_fail++; $display("FAIL skip_instret got=%0d want=3", instret_cnt); end
    out_ready = 1'b0;
    in_commit = mk(5, 1'b0, 4'h0);
    @(negedge clk);
    in_commit = mk(6, 1'b0, 4'h0);
    @(negedge clk);
    #2 reset = 1'b0;
    #1;
    n_checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin n_fail++; $display("FAIL midreset_io got valid=%0b ready=%0b want 0/1", out_valid, in_ready); end
    n_checks++; if (cycle_cnt !== 64'd0 || instret_cnt !== 64'd0 || halt !== 1'b0 || order_err !== 1'b0) begin n_fail++; $display("FAIL midreset_state got cyc=%0d ret=%0d halt=%0b err=%0b want all 0", cycle_cnt, instret_cnt, halt, order_err); end
    @(negedge clk);
    in_commit = '0;
    reset     = 1'b1;
    @(negedge clk);
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL midreset_discard got=%0b want=0", out_valid); end
  endtask

  initial begin
    test_reset();
    test_back_to_back();
    test_backpressure();
    test_full_push_pop();
    test_order();
    test_trap();
    test_skip_and_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
